// File: rtl/inst_encoder_if.sv
// Field-set / encoded-word channel for inst_encoder.
// The encoder binds to the slave modport; the producer/sink side uses master.
interface inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, addr_load, addr_in, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, addr_load, addr_in, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into a 32-bit instruction word.
// Two-stage valid/ready pipeline: S1 holds the captured fields, decoded format,
// error flag and address tag; S2 holds the packed word until the sink takes it.
// Optional feature macro: IMM_RANGE_CHECK_EN (flag immediates that do not fit
// their format; packing still truncates).
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        case (op)
            7'h33:                decode_fmt = FMT_R;
            7'h13, 7'h03, 7'h67:  decode_fmt = FMT_I;
            7'h23:                decode_fmt = FMT_S;
            7'h63:                decode_fmt = FMT_B;
            7'h6F:                decode_fmt = FMT_J;
            7'h37, 7'h17:         decode_fmt = FMT_U;
            default:              decode_fmt = FMT_R;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17:
                     opcode_known = 1'b1;
            default: opcode_known = 1'b0;
        endcase
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // True when the immediate cannot be represented exactly by the format.
    function automatic logic imm_bad(input fmt_e f, input logic [31:0] imm);
        case (f)
            FMT_I, FMT_S: imm_bad = (imm[31:11] != {21{imm[31]}});
            FMT_B:        imm_bad = (imm[31:12] != {20{imm[31]}}) || imm[0];
            FMT_J:        imm_bad = (imm[31:20] != {12{imm[31]}}) || imm[0];
            FMT_U:        imm_bad = (imm[11:0] != 12'd0);
            default:      imm_bad = 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [31:0] pack(
        input fmt_e        f,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        case (f)
            FMT_I:   pack = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   pack = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   pack = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   pack = {imm[31:12], rd, op};
            FMT_J:   pack = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: pack = {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    // S1 state
    logic              s1_valid_r;
    fmt_e              s1_fmt_r;
    logic              s1_err_r;
    logic [6:0]        s1_op_r;
    logic [4:0]        s1_rd_r;
    logic [4:0]        s1_rs1_r;
    logic [4:0]        s1_rs2_r;
    logic [2:0]        s1_f3_r;
    logic [6:0]        s1_f7_r;
    logic [31:0]       s1_imm_r;
    logic [ADDR_W-1:0] s1_addr_r;
    // S2 state
    logic              s2_valid_r;
    logic [31:0]       s2_inst_r;
    logic [ADDR_W-1:0] s2_addr_r;
    logic              s2_err_r;
    // Address counter
    logic [ADDR_W-1:0] addr_cnt_r;

    logic              s1_adv_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic [ADDR_W-1:0] tag_s;
    fmt_e              in_fmt_s;
    logic              in_err_s;

    assign s1_adv_s   = s1_valid_r && (!s2_valid_r || bus.out_ready);
    assign in_ready_s = !s1_valid_r || s1_adv_s;
    assign in_fire_s  = bus.in_valid && in_ready_s;
    // A same-cycle load overrides the counter for the word being accepted.
    assign tag_s      = bus.addr_load ? bus.addr_in : addr_cnt_r;
    assign in_fmt_s   = decode_fmt(bus.in_opcode);
`ifdef IMM_RANGE_CHECK_EN
    assign in_err_s   = !opcode_known(bus.in_opcode) || imm_bad(in_fmt_s, bus.in_imm);
`else
    assign in_err_s   = !opcode_known(bus.in_opcode);
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_inst  = s2_inst_r;
    assign bus.out_addr  = s2_addr_r;
    assign bus.out_err   = s2_err_r;

    // S1: capture fields, format, error and address tag on an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_fmt_r   <= FMT_R;
            s1_err_r   <= 1'b0;
            s1_op_r    <= 7'd0;
            s1_rd_r    <= 5'd0;
            s1_rs1_r   <= 5'd0;
            s1_rs2_r   <= 5'd0;
            s1_f3_r    <= 3'd0;
            s1_f7_r    <= 7'd0;
            s1_imm_r   <= 32'd0;
            s1_addr_r  <= {ADDR_W{1'b0}};
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_fmt_r   <= in_fmt_s;
            s1_err_r   <= in_err_s;
            s1_op_r    <= bus.in_opcode;
            s1_rd_r    <= bus.in_rd;
            s1_rs1_r   <= bus.in_rs1;
            s1_rs2_r   <= bus.in_rs2;
            s1_f3_r    <= bus.in_funct3;
            s1_f7_r    <= bus.in_funct7;
            s1_imm_r   <= bus.in_imm;
            s1_addr_r  <= tag_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Address counter: steps by 4 per accepted word, reloadable from addr_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt_r <= BASE_ADDR;
        end else if (in_fire_s) begin
            addr_cnt_r <= tag_s + ADDR_STEP;
        end else if (bus.addr_load) begin
            addr_cnt_r <= bus.addr_in;
        end
    end

    // S2: take the packed word when free or draining; otherwise hold it stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_inst_r  <= 32'd0;
            s2_addr_r  <= {ADDR_W{1'b0}};
            s2_err_r   <= 1'b0;
        end else if (!s2_valid_r || bus.out_ready) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_inst_r <= pack(s1_fmt_r, s1_op_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                                  s1_f3_r, s1_f7_r, s1_imm_r);
                s2_addr_r <= s1_addr_r;
                s2_err_r  <= s1_err_r;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver queues the expected word on each
// input handshake; a monitor pops and compares on each output handshake.
module tb_inst_encoder;
    logic clk;
    logic rst_n;

    inst_encoder_if #(.ADDR_W(32)) bus ();

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepts  = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic EXP_RANGE_ERR = 1'b1;
`else
    localparam logic EXP_RANGE_ERR = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
        bus.addr_in   = 32'h0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic ld, input logic [31:0] ain,
                        input logic [31:0] e_inst, input logic [31:0] e_addr, input logic e_err);
        bit done;
        int n;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.addr_load = ld;
        bus.addr_in   = ain;
        done = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.inst = e_inst;
                e.addr = e_addr;
                e.err  = e_err;
                q.push_back(e);
                accepts++;
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never seen for inst 0x%08h", e_inst);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", q.size());
        end
    endtask

    // Monitor: compare each accepted output and check holding while stalled.
    initial begin
        exp_t        e;
        logic        hold_pend;
        logic [31:0] h_inst;
        logic [31:0] h_addr;
        logic        h_err;
        hold_pend = 1'b0;
        h_inst = 32'h0;
        h_addr = 32'h0;
        h_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hold_pend) begin
                    checks++;
                    if (!bus.out_valid || bus.out_inst !== h_inst ||
                        bus.out_addr !== h_addr || bus.out_err !== h_err) begin
                        errors++;
                        $display("FAIL stall_hold: actual v=%0b inst=0x%08h addr=0x%08h err=%0b required v=1 inst=0x%08h addr=0x%08h err=%0b",
                                 bus.out_valid, bus.out_inst, bus.out_addr, bus.out_err,
                                 h_inst, h_addr, h_err);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: actual inst=0x%08h addr=0x%08h required none",
                                 bus.out_inst, bus.out_addr);
                    end else begin
                        e = q.pop_front();
                        check1("out_inst", bus.out_inst, e.inst);
                        check1("out_addr", bus.out_addr, e.addr);
                        check1("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
                    end
                end
                hold_pend = bus.out_valid && !bus.out_ready;
                h_inst = bus.out_inst;
                h_addr = bus.out_addr;
                h_err  = bus.out_err;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int acc0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_opcode = 7'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0;
        bus.in_imm    = 32'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check1("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check1("rst_out_inst", bus.out_inst, 32'd0);
        check1("rst_out_addr", bus.out_addr, 32'd0);
        check1("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addi x1, x0, -1 with latency check
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFF0_0093, 32'h0000_0000, 1'b0);
        idle();
        @(negedge clk);
        check1("latency_n1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check1("latency_n2", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // sw, beq, jal, lui, auipc, add, sub, unknown, addi 2048, lw
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         1'b0, 32'h0, 32'h0020_A423, 32'h0000_0004, 1'b0);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFE00_0EE3, 32'h0000_0008, 1'b0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,         1'b0, 32'h0, 32'h0080_00EF, 32'h0000_000C, 1'b0);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h0, 32'h1234_52B7, 32'h0000_0010, 1'b0);
        send(7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0, 32'h0, 32'h0000_1117, 32'h0000_0014, 1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0, 32'h0020_81B3, 32'h0000_0018, 1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        1'b0, 32'h0, 32'h4020_81B3, 32'h0000_001C, 1'b0);
        send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         1'b0, 32'h0, 32'h0000_007F, 32'h0000_0020, 1'b1);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      1'b0, 32'h0, 32'h8000_0093, 32'h0000_0024, EXP_RANGE_ERR);
        send(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd16,        1'b0, 32'h0, 32'h0101_2283, 32'h0000_0028, 1'b0);
        idle();
        drain();

        // Backpressure: 4 back-to-back words, sink stalled for 3 cycles
        acc0 = accepts;
        fork
            begin
                send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0, 32'h0010_0093, 32'h0000_002C, 1'b0);
                send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0, 32'h0020_0113, 32'h0000_0030, 1'b0);
                send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0, 32'h0030_0193, 32'h0000_0034, 1'b0);
                send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0, 32'h0, 32'h0040_0213, 32'h0000_0038, 1'b0);
                idle();
            end
            begin
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check1("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                check1("bp_accepts", accepts - acc0, 32'd2);
                check1("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Address counter: load alone, load with handshake, wrap
        bus.addr_load = 1'b1;
        bus.addr_in   = 32'h0000_0040;
        @(posedge clk);
        #1;
        idle();
        send(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0,         32'h0000_8067, 32'h0000_0040, 1'b0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h0000_0100, 32'h0010_0093, 32'h0000_0100, 1'b0);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0,         32'h0020_0113, 32'h0000_0104, 1'b0);
        send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, 32'hFFFF_FFFC, 32'h0030_0193, 32'hFFFF_FFFC, 1'b0);
        send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0, 32'h0,         32'h0040_0213, 32'h0000_0000, 1'b0);
        idle();
        drain();

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0, 32'h0050_0293, 32'h0000_0004, 1'b0);
        send(7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0, 32'h0, 32'h0060_0313, 32'h0000_0008, 1'b0);
        idle();
        #2;
        check1("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check1("mid_rst_out_inst", bus.out_inst, 32'd0);
        check1("mid_rst_out_addr", bus.out_addr, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'h0, 32'h0070_0393, 32'h0000_0000, 1'b0);
        idle();
        drain();
        repeat (5) @(posedge clk);
        #1;
        check1("post_rst_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
